// File: rtl/reg_scoreboard.sv
// Register write scoreboard: tracks pending writes per register and produces the
// decode stall. Optional macro WB_BYPASS_EN lets a same-cycle writeback release a RAW stall.
module reg_scoreboard #(
  parameter int MAX_PER_REG  = 3,
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_CNT_W  = 16,
  localparam int CNT_W       = $clog2(MAX_PER_REG + 1),
  localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ISSUE_VALID,
  input  logic [4:0]             ISSUE_RS1_ADDR,
  input  logic                   ISSUE_RS1_USED,
  input  logic [4:0]             ISSUE_RS2_ADDR,
  input  logic                   ISSUE_RS2_USED,
  input  logic [4:0]             ISSUE_RD_ADDR,
  input  logic                   ISSUE_RD_WRITE,
  input  logic                   WB_VALID,
  input  logic [4:0]             WB_ADDR,
  input  logic                   FLUSH,
  output logic                   ISSUE_READY,
  output logic                   STALL,
  output logic [31:0]            BUSY_VECTOR,
  output logic [INF_W-1:0]       INFLIGHT,
  output logic [STALL_CNT_W-1:0] STALL_CYCLES,
  output logic                   UNDERFLOW_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PER_REG);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 is never written, so R0 always reads as idle.
  logic [CNT_W-1:0] cnt_q [32];
  logic [31:0]      flushed_q;
  logic [INF_W-1:0] inflight_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic             underflow_q;

  logic rs1_busy;
  logic rs2_busy;
  logic raw_hz;
  logic struct_hz;
  logic acc;
  logic inc;
  logic wb_hit;
  logic dec;
  logic wb_under;

  always_comb begin
    rs1_busy = ISSUE_RS1_USED && (cnt_q[ISSUE_RS1_ADDR] != '0);
    rs2_busy = ISSUE_RS2_USED && (cnt_q[ISSUE_RS2_ADDR] != '0);
`ifdef WB_BYPASS_EN
    // Last pending write retiring this cycle is forwarded, so the source is free.
    if (WB_VALID && (WB_ADDR == ISSUE_RS1_ADDR) && (cnt_q[ISSUE_RS1_ADDR] == CNT_ONE))
      rs1_busy = 1'b0;
    if (WB_VALID && (WB_ADDR == ISSUE_RS2_ADDR) && (cnt_q[ISSUE_RS2_ADDR] == CNT_ONE))
      rs2_busy = 1'b0;
`endif
    raw_hz    = rs1_busy || rs2_busy;
    struct_hz = ISSUE_RD_WRITE && (ISSUE_RD_ADDR != 5'd0) &&
                ((cnt_q[ISSUE_RD_ADDR] == CNT_MAX) || (inflight_q == INF_MAX));
    acc       = ISSUE_VALID && !raw_hz && !struct_hz && !FLUSH;
    inc       = acc && ISSUE_RD_WRITE && (ISSUE_RD_ADDR != 5'd0);
    wb_hit    = WB_VALID && (WB_ADDR != 5'd0) && !FLUSH;
    dec       = wb_hit && (cnt_q[WB_ADDR] != '0);
    // Writebacks belonging to flushed writes land on a zero count and are masked.
    wb_under  = wb_hit && (cnt_q[WB_ADDR] == '0) && !flushed_q[WB_ADDR];
  end

  assign ISSUE_READY   = !raw_hz && !struct_hz;
  assign STALL         = ISSUE_VALID && !ISSUE_READY;
  assign INFLIGHT      = inflight_q;
  assign STALL_CYCLES  = stall_cnt_q;
  assign UNDERFLOW_ERR = underflow_q;

  always_comb begin
    BUSY_VECTOR = '0;
    for (int i = 1; i < 32; i++) BUSY_VECTOR[i] = (cnt_q[i] != '0);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      flushed_q   <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (STALL && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      underflow_q <= underflow_q || wb_under;
      if (FLUSH) begin
        for (int i = 1; i < 32; i++) begin
          cnt_q[i]     <= '0;
          flushed_q[i] <= flushed_q[i] || (cnt_q[i] != '0);
        end
        inflight_q <= '0;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (inc && (ISSUE_RD_ADDR == 5'(i))) begin
            flushed_q[i] <= 1'b0;
            if (!(dec && (WB_ADDR == 5'(i)))) cnt_q[i] <= cnt_q[i] + 1'b1;
          end else if (dec && (WB_ADDR == 5'(i))) begin
            cnt_q[i] <= cnt_q[i] - 1'b1;
          end
        end
        if (inc && !dec)      inflight_q <= inflight_q + 1'b1;
        else if (dec && !inc) inflight_q <= inflight_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; expectations are hand-computed.
module tb_reg_scoreboard;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RS1_ADDR;
  logic        ISSUE_RS1_USED;
  logic [4:0]  ISSUE_RS2_ADDR;
  logic        ISSUE_RS2_USED;
  logic [4:0]  ISSUE_RD_ADDR;
  logic        ISSUE_RD_WRITE;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic        FLUSH;
  logic        ISSUE_READY;
  logic        STALL;
  logic [31:0] BUSY_VECTOR;
  logic [2:0]  INFLIGHT;
  logic [15:0] STALL_CYCLES;
  logic        UNDERFLOW_ERR;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ISSUE_VALID(ISSUE_VALID),
    .ISSUE_RS1_ADDR(ISSUE_RS1_ADDR), .ISSUE_RS1_USED(ISSUE_RS1_USED),
    .ISSUE_RS2_ADDR(ISSUE_RS2_ADDR), .ISSUE_RS2_USED(ISSUE_RS2_USED),
    .ISSUE_RD_ADDR(ISSUE_RD_ADDR), .ISSUE_RD_WRITE(ISSUE_RD_WRITE),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .FLUSH(FLUSH),
    .ISSUE_READY(ISSUE_READY), .STALL(STALL), .BUSY_VECTOR(BUSY_VECTOR),
    .INFLIGHT(INFLIGHT), .STALL_CYCLES(STALL_CYCLES), .UNDERFLOW_ERR(UNDERFLOW_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ISSUE_VALID = 0; ISSUE_RS1_ADDR = 0; ISSUE_RS1_USED = 0;
    ISSUE_RS2_ADDR = 0; ISSUE_RS2_USED = 0; ISSUE_RD_ADDR = 0;
    ISSUE_RD_WRITE = 0; WB_VALID = 0; WB_ADDR = 0; FLUSH = 0;
  endtask

  task automatic wr(input logic [4:0] rd);
    idle();
    ISSUE_VALID = 1; ISSUE_RD_ADDR = rd; ISSUE_RD_WRITE = 1;
  endtask

  task automatic rd1(input logic [4:0] rs);
    idle();
    ISSUE_VALID = 1; ISSUE_RS1_ADDR = rs; ISSUE_RS1_USED = 1;
  endtask

  task automatic wb(input logic [4:0] a);
    idle();
    WB_VALID = 1; WB_ADDR = a;
  endtask

  task automatic do_reset();
    idle();
    #2 RESET_N = 0;
    #2 RESET_N = 1;
    tick();
  endtask

  initial begin
    idle();
    RESET_N = 0;
    #2;
    chk("rst_busy", BUSY_VECTOR, 0);
    chk("rst_ready", {31'd0, ISSUE_READY}, 1);
    chk("rst_stall", {31'd0, STALL}, 0);
    RESET_N = 1;
    tick();

    // 1: async reset mid-stream with cnt[5]=2
    wr(5); tick(); wr(5); tick();
    chk("t1_busy5", BUSY_VECTOR, 32'h20);
    chk("t1_inflight", {29'd0, INFLIGHT}, 2);
    rd1(5); #1;
    chk("t1_stall", {31'd0, STALL}, 1);
    tick();
    chk("t1_stallcyc", {16'd0, STALL_CYCLES}, 1);
    #2 RESET_N = 0;
    #1;
    chk("t1_rst_busy", BUSY_VECTOR, 0);
    chk("t1_rst_inf", {29'd0, INFLIGHT}, 0);
    chk("t1_rst_stallcyc", {16'd0, STALL_CYCLES}, 0);
    chk("t1_rst_ready", {31'd0, ISSUE_READY}, 1);
    idle();
    #1 RESET_N = 1;
    tick();

    // 2: RAW hazard and release timing
    wr(1); tick();
    rd1(1); #1;
    chk("t2_stall", {31'd0, STALL}, 1);
    tick();
    WB_VALID = 1; WB_ADDR = 1; #1;
`ifdef WB_BYPASS_EN
    chk("t2_ready_wbcyc", {31'd0, ISSUE_READY}, 1);
`else
    chk("t2_ready_wbcyc", {31'd0, ISSUE_READY}, 0);
`endif
    tick();
    WB_VALID = 0; #1;
    chk("t2_ready_after", {31'd0, ISSUE_READY}, 1);
    chk("t2_busy", BUSY_VECTOR, 0);
    idle(); tick();

    // 3: R0 is never tracked
    idle(); ISSUE_VALID = 1; ISSUE_RD_WRITE = 1; ISSUE_RS1_USED = 1; ISSUE_RS2_USED = 1; #1;
    chk("t3_ready", {31'd0, ISSUE_READY}, 1);
    tick();
    chk("t3_inflight", {29'd0, INFLIGHT}, 0);
    chk("t3_ready2", {31'd0, ISSUE_READY}, 1);
    wb(0); tick();
    chk("t3_uf", {31'd0, UNDERFLOW_ERR}, 0);

    // 4: global and per-register capacity
    for (int r = 2; r <= 5; r++) begin
      wr(5'(r)); tick();
    end
    chk("t4_inf4", {29'd0, INFLIGHT}, 4);
    chk("t4_busy", BUSY_VECTOR, 32'h3C);
    wr(6); #1;
    chk("t4_stall_cap", {31'd0, STALL}, 1);
    tick();
    WB_VALID = 1; WB_ADDR = 2; #1;
    chk("t4_stall_wbcyc", {31'd0, STALL}, 1);
    tick();
    WB_VALID = 0; #1;
    chk("t4_ready_after", {31'd0, ISSUE_READY}, 1);
    tick();
    chk("t4_inf_rd6", {29'd0, INFLIGHT}, 4);
    chk("t4_busy2", BUSY_VECTOR, 32'h78);
    for (int r = 3; r <= 6; r++) begin
      wb(5'(r)); tick();
    end
    chk("t4_inf0", {29'd0, INFLIGHT}, 0);
    for (int k = 0; k < 3; k++) begin
      wr(7); tick();
    end
    chk("t4_inf3", {29'd0, INFLIGHT}, 3);
    wr(7); #1;
    chk("t4_stall_waw", {31'd0, STALL}, 1);
    tick();
    chk("t4_inf3_hold", {29'd0, INFLIGHT}, 3);

    // 5: simultaneous issue/WB and flush priority
    wb(7); tick();
    chk("t5_inf2", {29'd0, INFLIGHT}, 2);
    wr(8); tick();
    chk("t5_inf3", {29'd0, INFLIGHT}, 3);
    wr(8); WB_VALID = 1; WB_ADDR = 8; #1;
    chk("t5_ready", {31'd0, ISSUE_READY}, 1);
    tick();
    chk("t5_busy8", {31'd0, BUSY_VECTOR[8]}, 1);
    chk("t5_inf_same", {29'd0, INFLIGHT}, 3);
    FLUSH = 1; tick();
    chk("t5_flush_busy", BUSY_VECTOR, 0);
    chk("t5_flush_inf", {29'd0, INFLIGHT}, 0);
    wb(7); tick();
    chk("t5_postflush_uf", {31'd0, UNDERFLOW_ERR}, 0);
    chk("t5_postflush_inf", {29'd0, INFLIGHT}, 0);

    // 6: sticky underflow and stall-cycle counter
    do_reset();
    wb(9); tick();
    chk("t6_uf_set", {31'd0, UNDERFLOW_ERR}, 1);
    chk("t6_uf_inf", {29'd0, INFLIGHT}, 0);
    idle(); FLUSH = 1; tick();
    idle(); tick();
    chk("t6_uf_hold", {31'd0, UNDERFLOW_ERR}, 1);
    wr(10); tick();
    idle(); ISSUE_VALID = 1; ISSUE_RS2_ADDR = 10; ISSUE_RS2_USED = 1;
    for (int k = 0; k < 10; k++) tick();
    chk("t6_stallcyc10", {16'd0, STALL_CYCLES}, 10);
    idle(); FLUSH = 1; tick();
    idle(); tick();
    chk("t6_stallcyc_flush", {16'd0, STALL_CYCLES}, 10);
    chk("t6_busy_flush", BUSY_VECTOR, 0);
    #2 RESET_N = 0;
    #1;
    chk("t6_uf_rst", {31'd0, UNDERFLOW_ERR}, 0);
    chk("t6_stallcyc_rst", {16'd0, STALL_CYCLES}, 0);
    RESET_N = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
